pulse_width_meter: RTL and testbench
====================================

# pulse_width_meter

Up-counting duration meter that turns a high pulse on `sig` into an 8-bit cycle count. It is the measuring counterpart of the loadable down-counter used elsewhere: that block spends a programmed number of cycles, and this one reports how many cycles a pulse lasted. The captured value can be loaded directly as `init` into the down-counter to replay the same interval. It sits between an external or level-type control input and the controller FSM, with a valid/ack handshake.

## Interface
- `WIDTH`, 8, width of the count and saturation limit (2^WIDTH-1).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `arm`  in  1  start a new measurement. Sampled on `clk`.
- `sig`  in  1  signal whose high-pulse width is measured.
- `ack`  in  1  consumer accepts the result. Meaningful only while `valid`=1.
- `count`  out  WIDTH  measured cycles. Internal counter register.
- `valid`  out  1  result available (state DONE).
- `busy`  out  1  high in ARMED or MEASURE.
- `ovf`  out  1  pulse exceeded 2^WIDTH-1 cycles. `count` is saturated.

## Operation
- `sig_s` is the sampled signal, either direct or synchronized (see Configuration). `sig_q` is `sig_s` delayed one cycle and updates every cycle in every state. A rising edge is `sig_s & ~sig_q`.
- States, 2-bit: IDLE=00, ARMED=01, MEASURE=10, DONE=11.
- IDLE:
  - `arm`=1 → ARMED, with `count`←0 and `ovf`←0.
  - Otherwise `count` and `ovf` hold.
- ARMED:
  - `arm`=1 → stays ARMED and clears again.
  - Rising edge → MEASURE, `count`←1.
  - A `sig_s` that was already high at arm time does not count. The meter waits for it to go low and rise again.
- MEASURE:
  - `arm`=1 → ARMED, clears (restart; has priority).
  - `sig_s`=1 → `count`←`count`+1. At 2^WIDTH-1 the count holds and `ovf`←1.
  - `sig_s`=0 → DONE. `count` is not incremented.
- DONE:
  - `ack`=1 → IDLE.
  - `arm` is ignored in DONE, including when it arrives in the same cycle as `ack`.
- Result: `count` = number of clk cycles on which `sig_s` was high, from the edge cycle through the last high cycle. `count` and `ovf` stay stable from DONE until the next accepted `arm`.
- Outputs:
  - `valid` = (state==DONE).
  - `busy` = state∈{ARMED, MEASURE}.
  - Both are decoded from the registered state, with no combinational path from inputs.
- Reset: state IDLE, `count`=0, `valid`=0, `busy`=0, `ovf`=0, `sig_q`=0, synchronizer flops 0. Reset in any state, including mid-MEASURE, discards the measurement.

## Timing
- `arm` sampled at edge k → `busy`=1 and `count`=0 after edge k.
- Latency, no synchronizer: a `sig` that is high for N whole cycles gives `valid`=1 one cycle after the first low sample. `count`=N.
- With the synchronizer, add 2 cycles to both edge detection and end detection. N is unchanged.
- `ack` at edge j → `valid`=0 after edge j. The earliest new `arm` is accepted at edge j+1.
- Minimum measurable pulse: 1 cycle, giving `count`=1.

## Configuration
- `PULSE_METER_SYNC_EN`:
  - Defined: `sig` passes through two flops, and `sig_s` is the second flop, so `sig` may be asynchronous.
  - Undefined: `sig_s`=`sig` directly, with no extra latency, and `sig` must be synchronous to `clk`.
- Count values are identical in both builds. Only the latency differs.

## Structure
- Shared package `pulse_meter_pkg`:
  - State encoding constants IDLE/ARMED/MEASURE/DONE.
  - Default `WIDTH`=8.
  - `CNT_MAX` = 2^WIDTH-1.
- Sub-module `edge_sync`:
  - Contains the optional 2-flop synchronizer (macro-controlled), the `sig_q` register and the rise detector.
  - Outputs `sig_s` and `rise`.
- Top level: FSM plus saturating counter.

## Test plan
- Reset asserted mid-MEASURE (`count`=7) → immediately `count`=0, `valid`=0, `busy`=0, `ovf`=0. After release, state IDLE.
- `arm`, then `sig` high 5 cycles → `valid`=1 with `count`=5, `ovf`=0. `ack` → `valid`=0 the next cycle.
- `sig` high when `arm` arrives, falling after 4 cycles, then a 3-cycle pulse → `count`=3, not 7.
- `sig` high 300 cycles with WIDTH=8 → `count`=255, `ovf`=1, `valid` after the fall.
- `arm` re-asserted during MEASURE at `count`=6 → ARMED, `count`=0. The next 2-cycle pulse gives 2.
- In DONE, `ack`=1 and `arm`=1 together → IDLE, `count` unchanged. Repeat with `PULSE_METER_SYNC_EN` defined and confirm the same counts with `valid` 2 cycles later.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse width meter: state encoding, default width, saturation limit.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    MEASURE = 2'b10,
    DONE    = 2'b11
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic logic [31:0] cnt_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [31:0] CNT_MAX = cnt_max(DEFAULT_WIDTH);

endpackage

// File: rtl/pulse_width_meter_edge_sync.sv
// Sampling front end for sig: optional 2-flop synchronizer (PULSE_METER_SYNC_EN),
// one-cycle delayed copy sig_q and rising-edge detect.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic sig_s,
  output logic rise
);

  logic sig_q, sig_d;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], sig};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= sync_d;
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig;
`endif

  // sig_q tracks sig_s in every state so a pulse already high at arm time never looks like an edge
  always_comb sig_d = sig_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_d;
  end

  assign rise = sig_s & ~sig_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the high-pulse width of sig in clk cycles, saturating at 2^WIDTH-1 with ovf.
// Build option: PULSE_METER_SYNC_EN adds a 2-flop synchronizer on sig (+2 cycles latency).
module pulse_width_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             sig,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SAT = WIDTH'(cnt_max(WIDTH));

  logic   sig_s, rise;
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic   ovf_q, ovf_d;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .sig   (sig),
    .sig_s (sig_s),
    .rise  (rise)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (arm) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (rise) begin
          state_d = MEASURE;
          count_d = WIDTH'(1);
        end
      end
      MEASURE: begin
        // Restart wins over both counting and end-of-pulse
        if (arm) begin
          state_d = ARMED;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (sig_s) begin
          if (count_q == SAT) ovf_d = 1'b1;
          else                count_d = count_q + WIDTH'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign valid = (state_q == DONE);
  assign busy  = (state_q == ARMED) || (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter; sync build shifts valid timing by 2 cycles.
module tb_pulse_width_meter;

`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, arm, sig, ack;
  logic [7:0] count;
  logic       valid, busy, ovf;
  int         tests = 0;
  int         fails = 0;

  pulse_width_meter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .arm   (arm),
    .sig   (sig),
    .ack   (ack),
    .count (count),
    .valid (valid),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; sig = 1'b0; ack = 1'b0;
    repeat (3) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_ovf",   32'(ovf),   0);
    rst = 1'b0;
    tick();

    // basic 5-cycle pulse
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_busy",  32'(busy),  1);
    chk("arm_count", 32'(count), 0);
    sig = 1'b1;
    repeat (5) tick();
    sig = 1'b0;
    repeat (LAT) tick();
    chk("p5_not_yet_valid", 32'(valid), 0);
    tick();
    chk("p5_valid", 32'(valid), 1);
    chk("p5_count", 32'(count), 5);
    chk("p5_ovf",   32'(ovf),   0);
    chk("p5_busy",  32'(busy),  0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_valid", 32'(valid), 0);
    chk("ack_count_hold", 32'(count), 5);

    // sig already high at arm: first pulse ignored
    sig = 1'b1;
    repeat (4) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (3) tick();
    sig = 1'b0;
    repeat (2) tick();
    chk("prehigh_busy", 32'(busy), 1);
    sig = 1'b1;
    repeat (3) tick();
    sig = 1'b0;
    repeat (LAT + 1) tick();
    chk("prehigh_valid", 32'(valid), 1);
    chk("prehigh_count", 32'(count), 3);
    ack = 1'b1; tick(); ack = 1'b0;

    // restart during MEASURE at count 6
    arm = 1'b1; tick(); arm = 1'b0;
    sig = 1'b1;
    repeat (6 + LAT) tick();
    chk("restart_pre_count", 32'(count), 6);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("restart_count", 32'(count), 0);
    chk("restart_busy",  32'(busy),  1);
    sig = 1'b0;
    repeat (2) tick();
    sig = 1'b1;
    repeat (2) tick();
    sig = 1'b0;
    repeat (LAT + 1) tick();
    chk("restart_valid", 32'(valid), 1);
    chk("restart_result", 32'(count), 2);

    // ack and arm together in DONE: arm ignored
    ack = 1'b1; arm = 1'b1; tick(); ack = 1'b0; arm = 1'b0;
    chk("ackarm_valid", 32'(valid), 0);
    chk("ackarm_busy",  32'(busy),  0);
    chk("ackarm_count", 32'(count), 2);
    tick();
    chk("ackarm_idle", 32'(busy), 0);

    // overflow: 300-cycle pulse
    arm = 1'b1; tick(); arm = 1'b0;
    sig = 1'b1;
    repeat (300) tick();
    chk("ovf_busy",  32'(busy),  1);
    chk("ovf_flag",  32'(ovf),   1);
    chk("ovf_count", 32'(count), 255);
    sig = 1'b0;
    repeat (LAT) tick();
    chk("ovf_not_yet_valid", 32'(valid), 0);
    tick();
    chk("ovf_valid", 32'(valid), 1);
    chk("ovf_hold_count", 32'(count), 255);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ovf_hold_after_ack", 32'(ovf), 1);

    // minimum 1-cycle pulse; arm clears ovf
    arm = 1'b1; tick(); arm = 1'b0;
    chk("min_ovf_clr", 32'(ovf), 0);
    sig = 1'b1; tick(); sig = 1'b0;
    repeat (LAT + 1) tick();
    chk("min_valid", 32'(valid), 1);
    chk("min_count", 32'(count), 1);
    ack = 1'b1; tick(); ack = 1'b0;

    // reset mid-MEASURE at count 7
    arm = 1'b1; tick(); arm = 1'b0;
    sig = 1'b1;
    repeat (7 + LAT) tick();
    chk("mid_count", 32'(count), 7);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_busy",  32'(busy),  0);
    chk("mid_rst_ovf",   32'(ovf),   0);
    sig = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_busy",  32'(busy),  0);
    chk("post_rst_valid", 32'(valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
